uart_tx: RTL



---
 rtl/uart_tx_pkg.sv | 27 ++
 rtl/uart_tx_if.sv | 34 +++
 rtl/uart_tx_q.sv | 24 ++
 rtl/uart_tx.sv | 134 +++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared UART transmitter types and frame constants.
// UART_TX_TWO_STOP_EN selects a two-stop-bit frame; otherwise one stop bit.
package uart_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        TX_STATE = 1'b1
    } tx_state_t;

    localparam int UART_Q_DEPTH = 128;
    localparam int UART_PTR_W   = 8;
    localparam int UART_ADDR_W  = 7;
    localparam int UART_BAUD_W  = 13;
    localparam int BIT_CNT_W    = 4;

`ifdef UART_TX_TWO_STOP_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    // Shift register image of a frame: stop bit(s), data, start bit in bit 0.
    function automatic logic [FRAME_BITS-1:0] frame_word(input logic [7:0] data);
        return {{(FRAME_BITS-9){1'b1}}, data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Processor-side bundle of the UART transmitter: write port, bit timing,
// serial line and queue status.
interface uart_tx_if;
    import uart_pkg::*;

    logic                   write_entry;
    logic [7:0]             tx_data;
    logic [UART_BAUD_W-1:0] baud_reload;
    logic                   TX;
    logic                   queue_full;
    logic [UART_PTR_W-1:0]  num_entries;
    logic                   tx_busy;

    modport master (
        output write_entry,
        output tx_data,
        output baud_reload,
        input  TX,
        input  queue_full,
        input  num_entries,
        input  tx_busy
    );

    modport slave (
        input  write_entry,
        input  tx_data,
        input  baud_reload,
        output TX,
        output queue_full,
        output num_entries,
        output tx_busy
    );

endinterface

// File: rtl/uart_tx_q.sv
// 128x8 transmit queue storage: synchronous write, combinational read so the
// head byte is available in the same cycle the frame is started.
module uart_tx_q
    import uart_pkg::*;
(
    input  logic                   clk,
    input  logic [UART_ADDR_W-1:0] waddr,
    input  logic [7:0]             wdata,
    input  logic                   we,
    input  logic [UART_ADDR_W-1:0] raddr,
    output logic [7:0]             rdata
);

    logic [7:0] mem [UART_Q_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx.sv
// Queued 8N1 serial transmitter; frames are sent back to back while bytes wait.
// Build option UART_TX_TWO_STOP_EN (see uart_pkg) adds a second stop bit.
module uart_tx
    import uart_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  bus
);

    tx_state_t              state_reg;
    tx_state_t              state_next;
    logic [UART_PTR_W-1:0]  wrt_ptr_reg;
    logic [UART_PTR_W-1:0]  rd_ptr_reg;
    logic [UART_PTR_W-1:0]  num_entries;
    logic                   queue_full;
    logic                   queue_empty;
    logic                   we;
    logic [7:0]             tx_data_head;
    logic [FRAME_BITS-1:0]  shift_reg;
    logic [UART_BAUD_W-1:0] baud_cnt_reg;
    logic [BIT_CNT_W-1:0]   bit_cnt_reg;
    logic                   tx_reg;
    logic                   tx_busy_reg;
    logic                   busy_next;
    logic                   start;
    logic                   shift;
    logic                   frame_done;

    // Pointers carry one extra bit so full and empty are distinguishable.
    assign num_entries = wrt_ptr_reg - rd_ptr_reg;
    assign queue_full  = (num_entries == UART_PTR_W'(UART_Q_DEPTH));
    assign queue_empty = (wrt_ptr_reg == rd_ptr_reg);
    assign we          = bus.write_entry & ~queue_full;

    uart_tx_q u_q (
        .clk   (clk),
        .waddr (wrt_ptr_reg[UART_ADDR_W-1:0]),
        .wdata (bus.tx_data),
        .we    (we),
        .raddr (rd_ptr_reg[UART_ADDR_W-1:0]),
        .rdata (tx_data_head)
    );

    assign shift      = (state_reg == TX_STATE) && (baud_cnt_reg == '0);
    assign frame_done = shift && (bit_cnt_reg == BIT_CNT_W'(FRAME_BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (!queue_empty) state_next = TX_STATE;
            TX_STATE: if (frame_done && queue_empty) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // A finished frame with more data waiting restarts directly: no idle gap.
    always_comb begin
        start     = 1'b0;
        busy_next = 1'b0;
        case (state_reg)
            IDLE: begin
                start = ~queue_empty;
            end
            TX_STATE: begin
                busy_next = 1'b1;
                start     = frame_done & ~queue_empty;
            end
            default: begin
                start     = 1'b0;
                busy_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrt_ptr_reg <= '0;
            rd_ptr_reg  <= '0;
        end else begin
            if (we) begin
                wrt_ptr_reg <= wrt_ptr_reg + 1'b1;
            end
            if (start) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    // baud_reload is only looked at on a (re)load, so mid-frame edits take
    // effect from the next bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg    <= '1;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
        end else if (start) begin
            shift_reg    <= frame_word(tx_data_head);
            baud_cnt_reg <= bus.baud_reload;
            bit_cnt_reg  <= '0;
        end else if (shift) begin
            shift_reg    <= {1'b1, shift_reg[FRAME_BITS-1:1]};
            baud_cnt_reg <= bus.baud_reload;
            bit_cnt_reg  <= bit_cnt_reg + 1'b1;
        end else if (state_reg == TX_STATE) begin
            baud_cnt_reg <= baud_cnt_reg - 1'b1;
        end
    end

    // TX and tx_busy share the same one-cycle delay so they stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_reg      <= 1'b1;
            tx_busy_reg <= 1'b0;
        end else begin
            tx_reg      <= shift_reg[0];
            tx_busy_reg <= busy_next;
        end
    end

    assign bus.TX          = tx_reg;
    assign bus.tx_busy     = tx_busy_reg;
    assign bus.queue_full  = queue_full;
    assign bus.num_entries = num_entries;

endmodule
